pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_skid_buf.sv | 37 +++
 rtl/pipe_stage_reg.sv | 95 +++++++++
 tb/tb_pipe_stage_reg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline definitions: control-field layout and default widths.
package pipe_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_CTRL_W = 8;
   localparam int DEF_CNT_W  = 16;

   // Bit positions of the EX/MEM control fields inside the packed ctrl word.
   localparam int MEM_READ_POS   = 0;
   localparam int MEM_WRITE_POS  = 1;
   localparam int REG_WRITE_POS  = 2;
   localparam int MEM_TO_REG_POS = 3;
   localparam int MEM_TO_REG_W   = 2;
   localparam int LW_LB_POS      = 5;
   localparam int CTRL_USED_W    = 6;

   typedef struct packed {
      logic [DEF_CTRL_W-CTRL_USED_W-1:0] spare;
      logic                              lw_lb;
      logic [MEM_TO_REG_W-1:0]           mem_to_reg;
      logic                              reg_write;
      logic                              mem_write;
      logic                              mem_read;
   } ex_mem_ctrl_t;

   function automatic ex_mem_ctrl_t unpack_ctrl(input logic [DEF_CTRL_W-1:0] raw);
      return ex_mem_ctrl_t'(raw);
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register holding a beat accepted while the output is stalled.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              unload,
   input  logic              clear,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   // clear only drops the valid bit; contents are dead once invalid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= in_ctrl;
         data  <= in_data;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// EX/MEM valid/ready pipeline register with flush and saturating stall counter.
// Define PIPE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              accept;
   logic              load_out;
   logic [CTRL_W-1:0] src_ctrl;
   logic [DATA_W-1:0] src_data;

`ifdef PIPE_SKID_EN
   logic              skid_valid;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              skid_load;
   logic              take_skid;

   // in_ready depends only on skid state, so out_ready never reaches it.
   assign in_ready  = ~skid_valid;
   assign accept    = in_valid & in_ready & ~flush;
   assign skid_load = accept & out_valid & ~out_ready;
   assign take_skid = out_valid & out_ready & skid_valid;
   assign load_out  = take_skid | (accept & ~skid_load);
   assign src_ctrl  = skid_valid ? skid_ctrl : in_ctrl;
   assign src_data  = skid_valid ? skid_data : in_data;

   pipe_skid_buf #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (skid_load),
      .unload  (take_skid),
      .clear   (flush),
      .in_ctrl (in_ctrl),
      .in_data (in_data),
      .valid   (skid_valid),
      .ctrl    (skid_ctrl),
      .data    (skid_data)
   );
`else
   // A flush cycle never advertises room; the presented beat is dropped.
   assign in_ready = (out_ready | ~out_valid) & ~flush;
   assign accept   = in_valid & in_ready;
   assign load_out = accept;
   assign src_ctrl = in_ctrl;
   assign src_data = in_data;
`endif

   // Payload is left untouched on flush/drain; only control bits are killed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
      end else if (load_out) begin
         out_valid <= 1'b1;
         out_ctrl  <= src_ctrl;
         out_data  <= src_data;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; follows PIPE_SKID_EN when defined.
module tb_pipe_stage_reg;

   localparam int DW = 32;
   localparam int CW = 8;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_ctrl = '0;
   logic [DW-1:0] in_data = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [NW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [CW-1:0] c, input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_ctrl  = c;
      in_data  = d;
   endtask

   initial begin
      // reset held
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_ctrl", out_ctrl, 0);
      chk("rst_data", out_data, 0);
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      reset_n = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 1);

      // stream 0x11, 0x22, 0x33
      out_ready = 1'b1;
      beat(8'h01, 32'h11); step();
      chk("s1_valid", out_valid, 1);
      chk("s1_data", out_data, 32'h11);
      chk("s1_ctrl", out_ctrl, 8'h01);
      beat(8'h02, 32'h22); step();
      chk("s2_valid", out_valid, 1);
      chk("s2_data", out_data, 32'h22);
      beat(8'h03, 32'h33); step();
      chk("s3_valid", out_valid, 1);
      chk("s3_data", out_data, 32'h33);
      chk("s3_ctrl", out_ctrl, 8'h03);
      in_valid = 1'b0; step();
      chk("drain_valid", out_valid, 0);
      chk("drain_data", out_data, 32'h33);
      chk("drain_ctrl", out_ctrl, 0);
      chk("drain_cnt", stall_cnt, 0);

      // backpressure: 0xAA held for 5 cycles, 0xBB waiting behind it
      beat(8'h0A, 32'hAA); step();
      chk("bp_load", out_data, 32'hAA);
      out_ready = 1'b0;
      beat(8'h0B, 32'hBB);
      #1;
`ifdef PIPE_SKID_EN
      chk("bp_in_ready_pre", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("bp_in_ready_skid", in_ready, 0);
`else
      chk("bp_in_ready_pre", in_ready, 0);
      step();
`endif
      repeat (4) step();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 32'hAA);
      chk("bp_ctrl", out_ctrl, 8'h0A);
      chk("bp_cnt", stall_cnt, 5);
      chk("bp_in_ready", in_ready, 0);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("bp_next_valid", out_valid, 1);
      chk("bp_next_data", out_data, 32'hBB);
      chk("bp_next_ctrl", out_ctrl, 8'h0B);
      step();
      chk("bp_no_dup", out_valid, 0);
      chk("bp_cnt_hold", stall_cnt, 5);

      // flush while stalled
      beat(8'hFF, 32'hC0); step();
      out_ready = 1'b0;
`ifdef PIPE_SKID_EN
      beat(8'h0D, 32'hD0);
`else
      in_valid = 1'b0;
`endif
      step();
      in_valid = 1'b0;
      chk("fl_pre_ctrl", out_ctrl, 8'hFF);
      chk("fl_pre_cnt", stall_cnt, 6);
      flush = 1'b1; step();
      flush = 1'b0;
      chk("fl_valid", out_valid, 0);
      chk("fl_ctrl", out_ctrl, 0);
      chk("fl_data", out_data, 32'hC0);
      // the flush edge itself is still a stalled edge, so it counts
      chk("fl_cnt", stall_cnt, 7);
      out_ready = 1'b1; step();
      chk("fl_skid_empty", out_valid, 0);
      chk("fl_in_ready", in_ready, 1);
      chk("fl_cnt_kept", stall_cnt, 7);

      // flush together with an offered beat
      beat(8'h05, 32'h55);
      flush = 1'b1; step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fa_valid", out_valid, 0);
      chk("fa_data", out_data, 32'hC0);
      step();
      chk("fa_valid2", out_valid, 0);

      // saturation of the 4-bit counter
      beat(8'h07, 32'h77); step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (20) step();
      chk("sat_cnt", stall_cnt, 15);
      chk("sat_data", out_data, 32'h77);

      // async reset between edges, mid-stall
      #2 reset_n = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_ctrl", out_ctrl, 0);
      chk("ar_data", out_data, 0);
      chk("ar_cnt", stall_cnt, 0);
      chk("ar_in_ready", in_ready, 1);
      step();
      #2 reset_n = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      chk("ar_no_stale", out_valid, 0);
      beat(8'h09, 32'h99); step();
      in_valid = 1'b0;
      chk("ar_new_valid", out_valid, 1);
      chk("ar_new_data", out_data, 32'h99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
